vip_gaussian_filter_3x3: RTL



---
 rtl/vip_gaussian_filter_3x3.sv | 132 +++++++++++++
 1 files changed

// File: rtl/vip_gaussian_filter_3x3.sv
// 3x3 Gaussian smoother ([1 2 1;2 4 2;1 2 1]/16) on an 8-bit luma stream.
// Two line buffers feed a 3x3 window; framing is delayed by exactly 3 clocks.
module vip_gaussian_filter_3x3 #(
  parameter int IMG_WIDTH = 640,
  parameter int CNT_W     = 11
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       per_frame_vsync,
  input  logic       per_frame_href,
  input  logic       per_frame_clken,
  input  logic [7:0] per_img_y,
  output logic       post_frame_vsync,
  output logic       post_frame_href,
  output logic       post_frame_clken,
  output logic [7:0] post_img_y
);
  localparam int STAGES = 3;
  localparam int AW     = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
  localparam logic [CNT_W-1:0] COL_MAX = CNT_W'(IMG_WIDTH);
  localparam logic [CNT_W-1:0] ROW_MAX = '1;

  typedef struct packed {
    logic vsync;
    logic href;
    logic clken;
  } ctl_t;

  ctl_t [STAGES:1]        ctl_pipe_q, ctl_pipe_d;
  logic [STAGES-1:1]      brd_q, brd_d;
  logic [CNT_W-1:0]       col_q, col_d, row_q, row_d;
  logic                   vsync_prev_q, vsync_prev_d, href_prev_q, href_prev_d;
  logic [2:0][2:0][7:0]   win_q, win_d;
  logic [2:0][9:0]        rsum_q, rsum_d;
  logic [7:0]             y_q, y_d;

  logic [7:0] lb0_mem [IMG_WIDTH];
  logic [7:0] lb1_mem [IMG_WIDTH];

  logic            accept, in_range, border, vsync_rise, href_fall;
  logic [AW-1:0]   addr;
  logic [2:0][7:0] tap;
  logic [11:0]     sum;

  always_comb begin
    accept     = per_frame_href & per_frame_clken;
    in_range   = col_q < COL_MAX;
    addr       = col_q[AW-1:0];
    vsync_rise = per_frame_vsync & ~vsync_prev_q;
    href_fall  = ~per_frame_href & href_prev_q;
    border     = (row_q < CNT_W'(2)) | (col_q < CNT_W'(2)) | ~in_range;

    // taps are rows r-2, r-1, r; reads see the contents before this write
    tap[0] = in_range ? lb0_mem[addr] : 8'd0;
    tap[1] = in_range ? lb1_mem[addr] : 8'd0;
    tap[2] = per_img_y;

    vsync_prev_d = per_frame_vsync;
    href_prev_d  = per_frame_href;

    col_d = col_q;
    if (!per_frame_href)                col_d = '0;
    else if (accept && col_q != COL_MAX) col_d = col_q + CNT_W'(1);

    // the vsync clear takes priority over a coincident line end
    row_d = row_q;
    if (vsync_rise)                        row_d = '0;
    else if (href_fall && row_q != ROW_MAX) row_d = row_q + CNT_W'(1);

    win_d = win_q;
    if (accept) begin
      for (int i = 0; i < 3; i++) begin
        win_d[i][2] = win_q[i][1];
        win_d[i][1] = win_q[i][0];
        win_d[i][0] = tap[i];
      end
    end

    for (int i = 0; i < 3; i++)
      rsum_d[i] = {2'b00, win_q[i][0]} + {1'b0, win_q[i][1], 1'b0} + {2'b00, win_q[i][2]};

    ctl_pipe_d[1].vsync = per_frame_vsync;
    ctl_pipe_d[1].href  = per_frame_href;
    ctl_pipe_d[1].clken = per_frame_clken;
    for (int s = 2; s <= STAGES; s++) ctl_pipe_d[s] = ctl_pipe_q[s-1];

    brd_d[1] = border;
    brd_d[2] = brd_q[1];

    sum = {2'b00, rsum_q[0]} + {1'b0, rsum_q[1], 1'b0} + {2'b00, rsum_q[2]} + 12'd8;

    y_d = y_q;
    if (!ctl_pipe_q[2].href)      y_d = 8'd0;
    else if (ctl_pipe_q[2].clken) y_d = brd_q[2] ? 8'd0 : 8'(sum >> 4);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ctl_pipe_q   <= '0;
      brd_q        <= '0;
      col_q        <= '0;
      row_q        <= '0;
      vsync_prev_q <= 1'b0;
      href_prev_q  <= 1'b0;
      win_q        <= '0;
      rsum_q       <= '0;
      y_q          <= '0;
    end else begin
      ctl_pipe_q   <= ctl_pipe_d;
      brd_q        <= brd_d;
      col_q        <= col_d;
      row_q        <= row_d;
      vsync_prev_q <= vsync_prev_d;
      href_prev_q  <= href_prev_d;
      win_q        <= win_d;
      rsum_q       <= rsum_d;
      y_q          <= y_d;
    end
  end

  always_ff @(posedge clk) begin
    if (accept && in_range) begin
      lb1_mem[addr] <= per_img_y;
      lb0_mem[addr] <= lb1_mem[addr];
    end
  end

  assign post_frame_vsync = ctl_pipe_q[STAGES].vsync;
  assign post_frame_href  = ctl_pipe_q[STAGES].href;
  assign post_frame_clken = ctl_pipe_q[STAGES].clken;
  assign post_img_y       = y_q;
endmodule
